// File: rtl/bcd_display_mux_pkg.sv
// Shared constants for the multiplexed 7-segment display driver:
// segment patterns (a = bit 0 ... g = bit 6) and digit-slot indices.
package bcd_display_pkg;

  localparam logic [1:0] IDX_ONES     = 2'd0;
  localparam logic [1:0] IDX_TENS     = 2'd1;
  localparam logic [1:0] IDX_HUNDREDS = 2'd2;

  typedef enum logic [1:0] {
    DIG_ONES     = IDX_ONES,
    DIG_TENS     = IDX_TENS,
    DIG_HUNDREDS = IDX_HUNDREDS
  } digit_e;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Index 0 is the rightmost element; codes 10-15 render as a lone dash.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    SEG_9, SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

endpackage

// File: rtl/bcd_display_mux_bcd_to_seg7.sv
// Combinational BCD digit to 7-segment pattern decoder with a blank override.
module bcd_to_seg7
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_OFF : SEG_TABLE[digit];

endmodule

// File: rtl/bcd_display_mux.sv
// Time-division multiplexed 3-digit 7-segment driver with per-frame snapshot,
// anti-ghosting blank gap and optional leading-zero suppression.
module bcd_display_mux
  import bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [11:0] bcd_in,
  input  logic        lz_blank,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  digit_e           d_reg, d_next;
  logic [11:0]      snap_reg, snap_next;
  logic [6:0]       seg_reg, seg_next;
  logic [2:0]       an_reg, an_next;
  logic             frame_start_reg, frame_start_next;

  logic [3:0] cur_digit;
  logic       cur_blank;
  logic [6:0] dec_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      d_reg           <= DIG_ONES;
      snap_reg        <= '0;
      seg_reg         <= SEG_OFF;
      an_reg          <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      d_reg           <= d_next;
      snap_reg        <= snap_next;
      seg_reg         <= seg_next;
      an_reg          <= an_next;
      frame_start_reg <= frame_start_next;
    end
  end

  // Digit selection from the snapshot; zero suppression looks at live lz_blank.
  always_comb begin
    cur_digit = snap_reg[3:0];
    cur_blank = 1'b0;
    case (d_reg)
      DIG_TENS: begin
        cur_digit = snap_reg[7:4];
        cur_blank = lz_blank && (snap_reg[11:8] == 4'd0) && (snap_reg[7:4] == 4'd0);
      end
      DIG_HUNDREDS: begin
        cur_digit = snap_reg[11:8];
        cur_blank = lz_blank && (snap_reg[11:8] == 4'd0);
      end
      default: begin
        cur_digit = snap_reg[3:0];
        cur_blank = 1'b0;
      end
    endcase
  end

  bcd_to_seg7 u_dec (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (dec_seg)
  );

  always_comb begin
    cnt_next         = cnt_reg;
    d_next           = d_reg;
    snap_next        = snap_reg;
    seg_next         = SEG_OFF;
    an_next          = 3'b000;
    frame_start_next = 1'b0;

    if (ena) begin
      // Snapshot cycle is always inside the blank gap, so frames never tear.
      if (d_reg == DIG_ONES && cnt_reg == '0) begin
        frame_start_next = 1'b1;
        snap_next        = bcd_in;
      end

      if (cnt_reg == CNT_MAX) begin
        cnt_next = '0;
        case (d_reg)
          DIG_ONES: d_next = DIG_TENS;
          DIG_TENS: d_next = DIG_HUNDREDS;
          default:  d_next = DIG_ONES;
        endcase
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end

      if (cnt_reg >= BLANK_LIM) begin
        seg_next = dec_seg;
        case (d_reg)
          DIG_ONES:     an_next = 3'b001;
          DIG_TENS:     an_next = 3'b010;
          DIG_HUNDREDS: an_next = 3'b100;
          default:      an_next = 3'b000;
        endcase
      end
    end
  end

  assign seg         = seg_reg;
  assign an          = an_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed + randomized bench for bcd_display_mux against a frame-position model.
module tb_bcd_display_mux;

  localparam int R = 8;
  localparam int B = 2;
  localparam int FRAME = 3 * R;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [11:0] bcd_in;
  logic        lz_blank;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame_start;

  bcd_display_mux #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .bcd_in      (bcd_in),
    .lz_blank    (lz_blank),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: position within the frame and the three snapshotted digits.
  int pos = 0;
  int snap_d [3] = '{0, 0, 0};
  logic [6:0] exp_seg;
  logic [2:0] exp_an;
  logic       exp_fs;

  function automatic logic [6:0] ref_seg(input int v);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (v < 10) ? tbl[v] : 7'h40;
  endfunction

  task automatic check_outputs(input string tag);
    vectors++;
    assert (seg === exp_seg) else begin
      miscompares++;
      $error("FAIL %s seg: observed %h expected %h (pos %0d)", tag, seg, exp_seg, pos);
    end
    vectors++;
    assert (an === exp_an) else begin
      miscompares++;
      $error("FAIL %s an: observed %b expected %b (pos %0d)", tag, an, exp_an, pos);
    end
    vectors++;
    assert (frame_start === exp_fs) else begin
      miscompares++;
      $error("FAIL %s frame_start: observed %b expected %b (pos %0d)", tag, frame_start, exp_fs, pos);
    end
  endtask

  // One clock: predict from current inputs, advance the model, compare after the edge.
  task automatic tick(input string tag);
    int slot, off;
    bit dark;
    exp_seg = 7'h00;
    exp_an  = 3'b000;
    exp_fs  = 1'b0;
    if (rst_n && ena) begin
      if (pos == 0) begin
        exp_fs = 1'b1;
        snap_d[0] = int'(bcd_in[3:0]);
        snap_d[1] = int'(bcd_in[7:4]);
        snap_d[2] = int'(bcd_in[11:8]);
      end
      slot = pos / R;
      off  = pos % R;
      if (off >= B) begin
        exp_an = 3'(1 << slot);
        dark = lz_blank && ((slot == 2 && snap_d[2] == 0) ||
                            (slot == 1 && snap_d[2] == 0 && snap_d[1] == 0));
        exp_seg = dark ? 7'h00 : ref_seg(snap_d[slot]);
      end
      pos = (pos + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    $display("cyc pos=%0d ena=%b bcd=%h lz=%b -> seg=%h an=%b fs=%b [%s]",
             pos, ena, bcd_in, lz_blank, seg, an, frame_start, tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic run_until(input int target, input string tag);
    for (int i = 0; i < 4 * FRAME && pos != target; i++) tick(tag);
    vectors++;
    assert (pos == target) else begin
      miscompares++;
      $error("FAIL %s reach_pos: observed %0d expected %0d", tag, pos, target);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    bcd_in   = 12'h123;
    lz_blank = 1'b0;
    #1;
    run(3, "reset");
    rst_n = 1'b1;

    // First frame after reset, then tear-free update during the tens slot.
    run_until(R + 3, "first_frame");
    bcd_in = 12'h456;
    run(2 * FRAME, "tear_free");

    // Leading-zero suppression.
    lz_blank = 1'b1;
    bcd_in   = 12'h007;
    run(2 * FRAME, "lz_007");
    bcd_in = 12'h070;
    run(2 * FRAME, "lz_070");
    bcd_in = 12'h000;
    run(2 * FRAME, "lz_000");

    // Invalid digits, with and without suppression (dash hundreds is not zero).
    bcd_in = 12'hA0F;
    run(2 * FRAME, "invalid_lz");
    lz_blank = 1'b0;
    run(2 * FRAME, "invalid");

    // Enable freeze mid-tens-slot.
    bcd_in = 12'h258;
    run_until(R + 4, "pre_freeze");
    ena = 1'b0;
    run(5, "freeze");
    ena = 1'b1;
    run(2 * FRAME, "resume");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bcd_in = 12'($urandom);
      if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0)
        bcd_in = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      tick("random");
    end
    ena = 1'b1;

    // Asynchronous reset during the hundreds slot.
    bcd_in   = 12'h987;
    lz_blank = 1'b0;
    run_until(2 * R + 4, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    pos = 0;
    snap_d = '{0, 0, 0};
    exp_seg = 7'h00;
    exp_an  = 3'b000;
    exp_fs  = 1'b0;
    check_outputs("async_reset");
    tick("in_reset");
    rst_n  = 1'b1;
    bcd_in = 12'h314;
    run(2 * FRAME, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
